// File: rtl/sram_porta_arbiter.sv
// Shares SRAM port A between a 32-bit config master and an 8-lane DMA master.
// Config wins contention until the DMA has lost STARVE_MAX cycles in a row.
module sram_porta_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int RD_LAT     = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_conf_rden,
    input  logic             i_conf_wren,
    input  logic [31:0]      i_conf_addr,
    input  logic [31:0]      i_conf_wdata,
    output logic             o_conf_gnt,
    output logic [31:0]      o_conf_rdata,
    output logic             o_conf_rvalid,
    input  logic             i_dma_rden,
    input  logic             i_dma_wren,
    input  logic [31:0]      i_dma_addr,
    input  logic [255:0]     i_dma_wdata,
    input  logic [7:0]       i_dma_wstrb,
    input  logic [7:0]       i_dma_winc,
    output logic             o_dma_gnt,
    output logic [255:0]     o_dma_rdata,
    output logic             o_dma_rvalid,
    output logic [7:0]       o_ram_rden,
    output logic [7:0]       o_ram_wren,
    output logic [7:0][31:0] o_ram_addr,
    output logic [7:0][31:0] o_ram_wdata,
    input  logic [7:0][31:0] i_ram_rdata
);

    typedef enum logic {CONF_PRI, DMA_PRI} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic [3:0]        starve_nxt;
    logic              conf_act;
    logic              dma_act;
    logic              conf_rd;
    logic              dma_rd;
    logic              tag_in_valid;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_owner;
    logic [2:0]        tag_lane [RD_LAT];

    // A request with both enables set is a write, so a read needs wren low.
    assign conf_act = i_conf_rden | i_conf_wren;
    assign dma_act  = i_dma_rden | i_dma_wren;
    assign conf_rd  = i_conf_rden & ~i_conf_wren;
    assign dma_rd   = i_dma_rden & ~i_dma_wren;

    always_comb begin
        o_conf_gnt = 1'b0;
        o_dma_gnt  = 1'b0;
        if (i_rst_n) begin
            if (conf_act && dma_act) begin
                o_conf_gnt = (state == CONF_PRI);
                o_dma_gnt  = (state == DMA_PRI);
            end else begin
                o_conf_gnt = conf_act;
                o_dma_gnt  = dma_act;
            end
        end
    end

    always_comb begin
        o_ram_rden  = '0;
        o_ram_wren  = '0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        for (int k = 0; k < 8; k++) begin
            if (o_dma_gnt) begin
                o_ram_addr[k]  = i_dma_addr + {31'd0, i_dma_winc[k]};
                o_ram_wdata[k] = i_dma_wdata[32*k +: 32];
            end else begin
                o_ram_addr[k]  = {3'b000, i_conf_addr[31:3]};
                o_ram_wdata[k] = i_conf_wdata;
            end
        end
        if (o_conf_gnt) begin
            if (i_conf_wren) o_ram_wren = 8'd1 << i_conf_addr[2:0];
            else             o_ram_rden = 8'hFF;
        end else if (o_dma_gnt) begin
            if (i_dma_wren) o_ram_wren = i_dma_wstrb;
            else            o_ram_rden = 8'hFF;
        end
    end

    always_comb begin
        if (o_dma_gnt || !dma_act) starve_nxt = '0;
        else if (o_conf_gnt)       starve_nxt = starve_cnt + 4'd1;
        else                       starve_nxt = starve_cnt;
    end

    // Switch on the same edge the counter reaches the limit, so the very next
    // contention cycle already goes to the DMA.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= CONF_PRI;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            case (state)
                CONF_PRI: if (starve_nxt == STARVE_LIM) state <= DMA_PRI;
                DMA_PRI:  if (o_dma_gnt) state <= CONF_PRI;
                default:  state <= CONF_PRI;
            endcase
        end
    end

    assign tag_in_valid = (o_conf_gnt & conf_rd) | (o_dma_gnt & dma_rd);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_lane[i] <= 3'd0;
        end else begin
            tag_valid[0] <= tag_in_valid;
            tag_owner[0] <= o_dma_gnt;
            tag_lane[0]  <= i_conf_addr[2:0];
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
                tag_lane[i]  <= tag_lane[i-1];
            end
        end
    end

    assign o_conf_rvalid = tag_valid[RD_LAT-1] & ~tag_owner[RD_LAT-1];
    assign o_dma_rvalid  = tag_valid[RD_LAT-1] &  tag_owner[RD_LAT-1];
    assign o_conf_rdata  = o_conf_rvalid ? i_ram_rdata[tag_lane[RD_LAT-1]] : 32'd0;
    assign o_dma_rdata   = o_dma_rvalid ? i_ram_rdata : 256'd0;

endmodule

// File: tb/tb_sram_porta_arbiter.sv
// Bench for sram_porta_arbiter: a grant/return model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_sram_porta_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int RD_LAT     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             conf_rden = 1'b0, conf_wren = 1'b0;
    logic [31:0]      conf_addr = '0, conf_wdata = '0;
    logic             conf_gnt, conf_rvalid;
    logic [31:0]      conf_rdata;
    logic             dma_rden = 1'b0, dma_wren = 1'b0;
    logic [31:0]      dma_addr = '0;
    logic [255:0]     dma_wdata = '0;
    logic [7:0]       dma_wstrb = '0, dma_winc = '0;
    logic             dma_gnt, dma_rvalid;
    logic [255:0]     dma_rdata;
    logic [7:0]       ram_rden, ram_wren;
    logic [7:0][31:0] ram_addr, ram_wdata, ram_rdata;

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    typedef struct {int due; bit owner; int lane;} rd_t;
    rd_t rq[$];
    int  losses = 0;
    bit  owed = 1'b0;

    sram_porta_arbiter #(.STARVE_MAX(STARVE_MAX), .RD_LAT(RD_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_conf_rden(conf_rden), .i_conf_wren(conf_wren),
        .i_conf_addr(conf_addr), .i_conf_wdata(conf_wdata),
        .o_conf_gnt(conf_gnt), .o_conf_rdata(conf_rdata), .o_conf_rvalid(conf_rvalid),
        .i_dma_rden(dma_rden), .i_dma_wren(dma_wren),
        .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
        .i_dma_wstrb(dma_wstrb), .i_dma_winc(dma_winc),
        .o_dma_gnt(dma_gnt), .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
        .o_ram_rden(ram_rden), .o_ram_wren(ram_wren),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM read data carries the cycle number and lane, so a wrong lane or
    // a wrong return cycle both show up in the data.
    function automatic logic [31:0] ramWord(input int c, input int k);
        return {16'(c), 8'h5A, 8'(k)};
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) ram_rdata[k] = ramWord(cyc, k);
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic applyStimulus(input logic rst, input logic crd, input logic cwr,
                                 input logic [31:0] ca, input logic [31:0] cwd,
                                 input logic drd, input logic dwr, input logic [31:0] da,
                                 input logic [7:0] ws, input logic [7:0] wi);
        @(posedge clk);
        #1;
        rst_n      = rst;
        conf_rden  = crd;
        conf_wren  = cwr;
        conf_addr  = ca;
        conf_wdata = cwd;
        dma_rden   = drd;
        dma_wren   = dwr;
        dma_addr   = da;
        dma_wstrb  = ws;
        dma_winc   = wi;
        for (int k = 0; k < 8; k++) dma_wdata[32*k +: 32] = da + 32'(32'h1111_1111 * (k + 1));
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
    endtask

    // Model: a lost-cycle tally and an "owed" flag decide contention; granted
    // reads are queued with their due cycle and popped when they return.
    always @(negedge clk) begin
        logic             c_act, d_act, eg_c, eg_d, e_crv, e_drv;
        logic [7:0]       e_rden, e_wren;
        logic [7:0][31:0] e_addr, e_wd;
        logic [31:0]      e_crd;
        logic [255:0]     e_drd;
        e_crv = 1'b0; e_drv = 1'b0; e_crd = '0; e_drd = '0;
        if (!rst_n) begin
            rq.delete();
            losses = 0;
            owed   = 1'b0;
            checkOutput("rst_conf_gnt", conf_gnt, 0);
            checkOutput("rst_dma_gnt", dma_gnt, 0);
            checkOutput("rst_rden", ram_rden, 0);
            checkOutput("rst_wren", ram_wren, 0);
        end else begin
            c_act = conf_rden | conf_wren;
            d_act = dma_rden | dma_wren;
            if (c_act && d_act) begin
                eg_d = owed;
                eg_c = !owed;
            end else begin
                eg_c = c_act;
                eg_d = d_act;
            end
            checkOutput("conf_gnt", conf_gnt, eg_c);
            checkOutput("dma_gnt", dma_gnt, eg_d);
            e_rden = 8'h00;
            e_wren = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (eg_d) begin
                    e_addr[k] = dma_addr + 32'(dma_winc[k]);
                    e_wd[k]   = dma_wdata[32*k +: 32];
                end else begin
                    e_addr[k] = conf_addr / 8;
                    e_wd[k]   = conf_wdata;
                end
            end
            if (eg_c) begin
                if (conf_wren) e_wren[conf_addr[2:0]] = 1'b1;
                else           e_rden = 8'hFF;
            end else if (eg_d) begin
                if (dma_wren) e_wren = dma_wstrb;
                else          e_rden = 8'hFF;
            end
            checkOutput("ram_rden", ram_rden, e_rden);
            checkOutput("ram_wren", ram_wren, e_wren);
            if (eg_c || eg_d) checkOutput("ram_addr", ram_addr, e_addr);
            if (e_wren != 8'h00) checkOutput("ram_wdata", ram_wdata, e_wd);
            if (eg_c && conf_rden && !conf_wren) rq.push_back('{cyc + RD_LAT, 1'b0, int'(conf_addr[2:0])});
            if (eg_d && dma_rden && !dma_wren)   rq.push_back('{cyc + RD_LAT, 1'b1, 0});
            if (eg_d) begin
                owed   = 1'b0;
                losses = 0;
            end else if (!d_act) begin
                losses = 0;
            end else if (eg_c) begin
                losses++;
                if (losses >= STARVE_MAX) owed = 1'b1;
            end
        end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].owner) begin
                e_drv = 1'b1;
                for (int k = 0; k < 8; k++) e_drd[32*k +: 32] = ramWord(cyc, k);
            end else begin
                e_crv = 1'b1;
                e_crd = ramWord(cyc, rq[0].lane);
            end
            void'(rq.pop_front());
        end
        checkOutput("conf_rvalid", conf_rvalid, e_crv);
        checkOutput("dma_rvalid", dma_rvalid, e_drv);
        checkOutput("conf_rdata", conf_rdata, e_crd);
        checkOutput("dma_rdata", dma_rdata, e_drd);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence; literal expectations below pin the model's own rules.
    initial begin
        logic [9:0]   dseq, cseq;
        logic [255:0] exp_d;
        int           t0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h5, 32'd0, 1'b1, 1'b0, 32'h10, 8'd0, 8'd0);
            checkOutput("reset_gnt_pair", {conf_gnt, dma_gnt}, 2'b00);
            checkOutput("reset_rvalid_pair", {conf_rvalid, dma_rvalid}, 2'b00);
        end
        idle();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'(i), 32'd0, 1'b1, 1'b0, 32'h80 + 32'(i), 8'd0, 8'd0);
            dseq[i] = dma_gnt;
            cseq[i] = conf_gnt;
        end
        checkOutput("starve_seq_dma", dseq, 10'b10_0001_0000);
        checkOutput("starve_seq_conf", cseq, 10'b01_1110_1111);
        repeat (3) idle();

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        checkOutput("cw_gnt", conf_gnt, 1);
        checkOutput("cw_wren", ram_wren, 8'b0000_1000);
        checkOutput("cw_addr", ram_addr, {8{32'h2}});
        checkOutput("cw_wdata_lane3", ram_wdata[3], 32'hDEAD_BEEF);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h10, 8'd0, 8'hF0);
        t0 = cyc;
        checkOutput("dr_addr", ram_addr, {{4{32'h11}}, {4{32'h10}}});
        checkOutput("dr_rden", ram_rden, 8'hFF);
        idle();
        checkOutput("dr_rvalid_t1", dma_rvalid, 0);
        idle();
        for (int k = 0; k < 8; k++) exp_d[32*k +: 32] = ramWord(t0 + 2, k);
        checkOutput("dr_rvalid_t2", dma_rvalid, 1);
        checkOutput("dr_rdata_t2", dma_rdata, exp_d);
        idle();

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h5, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h40, 8'd0, 8'd0);
        idle();
        checkOutput("alt_c_pair", {conf_rvalid, dma_rvalid}, 2'b10);
        checkOutput("alt_c_data", conf_rdata, ramWord(t0 + 2, 5));
        idle();
        checkOutput("alt_d_pair", {conf_rvalid, dma_rvalid}, 2'b01);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'hA5, 8'h0F);
        checkOutput("wrap_lane0", ram_addr[0], 32'h0);
        checkOutput("wrap_lane7", ram_addr[7], 32'hFFFF_FFFF);
        checkOutput("dw_wren", ram_wren, 8'hA5);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1E, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        checkOutput("crw_is_write", {ram_rden, ram_wren}, {8'h00, 8'b0100_0000});
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h300, 8'h3C, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h100, 8'd0, 8'h55);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h7, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h200, 8'd0, 8'd0);
        repeat (3) idle();

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b1, 32'h400, 8'hFF, 8'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        checkOutput("dmapri_conf_alone", conf_gnt, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 8'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("post_rst_no_rvalid", conf_rvalid, 0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'h1, 1'b0, 1'b1, 32'h400, 8'hFF, 8'd0);
        checkOutput("post_rst_conf_wins", {conf_gnt, dma_gnt}, 2'b10);
        repeat (3) idle();

        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
